// File: rtl/risc16_prog_loader.sv
// Framed byte-stream loader that fills the RISC_16_bit instruction memory while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.

// Protocol invariants on the loader outputs.
module risc16_prog_loader_chk (
  input logic clk,
  input logic rst,
  input logic in_ready,
  input logic cpu_hold,
  input logic load_done
);
  // The completion pulse releases the CPU, blocks input and lasts a single cycle.
  a_done_release : assert property (@(posedge clk) disable iff (rst)
    load_done |-> (!cpu_hold && !in_ready));
  a_done_pulse : assert property (@(posedge clk) disable iff (rst)
    load_done |=> !load_done);
endmodule

module risc16_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_e;

  // State entered once the last data byte (or a zero count) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_TAIL = S_CSUM;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [7:0]            lo_q, lo_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic                  accept_s;
  logic                  count_big_s;

  assign accept_s    = in_valid && in_ready_q;
  assign count_big_s = ({24'd0, in_data} > DEPTH);

  // Next-state and registered-output logic for the frame parser.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    lo_d         = lo_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_err_d   = load_err_q;
    load_done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_d    = S_COUNT;
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
          addr_d     = {ADDR_WIDTH{1'b0}};
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        if (!accept_s) begin
          state_d = S_COUNT;
        end else if (count_big_s) begin
          load_err_d = 1'b1;
          state_d    = S_IDLE;
        end else if (in_data == 8'h00) begin
          state_d = S_TAIL;
        end else begin
          remaining_d = CNT_W'(in_data);
          state_d     = S_LO;
        end
      end
      S_LO: begin
        if (accept_s) begin
          lo_d    = in_data;
          state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_fold(csum_q, in_data);
`endif
        end else begin
          state_d = S_LO;
        end
      end
      S_HI: begin
        if (accept_s) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_q;
          imem_wdata_d = {in_data, lo_q};
          addr_d       = addr_q + ADDR_WIDTH'(1'b1);
          remaining_d  = remaining_q - CNT_W'(1'b1);
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum_fold(csum_q, in_data);
`endif
          if (remaining_q == CNT_W'(1'b1)) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_LO;
          end
        end else begin
          state_d = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!accept_s) begin
          state_d = S_CSUM;
        end else if (in_data == csum_q) begin
          state_d = S_DONE;
        end else begin
          load_err_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entering DONE is the only way the CPU gets released.
    if (state_d == S_DONE) begin
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
    end else begin
      load_done_d = 1'b0;
    end
    in_ready_d = (state_d != S_DONE);
  end

  // State and output registers; reset also drops any write queued for this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= {ADDR_WIDTH{1'b0}};
      remaining_q  <= {CNT_W{1'b0}};
      lo_q         <= 8'h00;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {ADDR_WIDTH{1'b0}};
      imem_wdata_q <= 16'h0000;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      lo_q         <= lo_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

  risc16_prog_loader_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_ready (in_ready),
    .cpu_hold (cpu_hold),
    .load_done(load_done)
  );
endmodule

// File: tb/tb_risc16_prog_loader.sv
// Table-driven bench for risc16_prog_loader; frames carry a checksum byte when LOADER_CHECKSUM_EN is defined.
module tb_risc16_prog_loader;
  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        rdy;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        hold;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  risc16_prog_loader #(.ADDR_WIDTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs applied before an edge, outputs expected just after it
  function automatic void pv(input logic r, input logic [7:0] d, input logic v,
                             input logic rdy, input logic we, input logic [3:0] a,
                             input logic [15:0] wd, input logic hold, input logic done,
                             input logic err);
    vec_t t;
    t.rst = r; t.data = d; t.valid = v; t.rdy = rdy; t.we = we;
    t.addr = a; t.wd = wd; t.hold = hold; t.done = done; t.err = err;
    vecs.push_back(t);
  endfunction

  task automatic chk(input int idx, input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  initial begin
    logic [3:0]  la;
    logic [15:0] lw;
    logic [7:0]  lo_b;
    logic [7:0]  hi_b;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0;

    // reset state, garbage before sync, good two-word frame with a valid-low stall
    pv(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h34, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h12, 1'b1, 1'b1, 1'b1, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h78, 1'b1, 1'b1, 1'b0, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    pv(1'b0, 8'h56, 1'b1, 1'b1, 1'b1, 4'd1, 16'h5678, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 4'd1, 16'h5678, 1'b0, 1'b1, 1'b0);
`else
    pv(1'b0, 8'h56, 1'b1, 1'b0, 1'b1, 4'd1, 16'h5678, 1'b0, 1'b1, 1'b0);
`endif
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 16'h5678, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum keeps the write, sets err, keeps hold; next good frame clears both
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd1, 16'h5678, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 4'd1, 16'h5678, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 4'd1, 16'h5678, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'hBB, 1'b1, 1'b1, 1'b1, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b1);
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b1);
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 4'd0, 16'hBBAA, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 4'd0, 16'h2211, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 4'd0, 16'h2211, 1'b0, 1'b1, 1'b0);
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 16'h2211, 1'b0, 1'b0, 1'b0);
    la = 4'd0; lw = 16'h2211;
`else
    la = 4'd1; lw = 16'h5678;
`endif

    // oversize count 0x11, stray byte ignored, then a full-depth frame of 16 words
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h11, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b1);
    pv(1'b0, 8'h05, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b1);
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h10, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      lo_b = 8'(k);
      hi_b = 8'hC0 | 8'(k);
      pv(1'b0, lo_b, 1'b1, 1'b1, 1'b0, la, lw, 1'b1, 1'b0, 1'b0);
      la = 4'(k);
      lw = {hi_b, lo_b};
`ifdef LOADER_CHECKSUM_EN
      pv(1'b0, hi_b, 1'b1, 1'b1, 1'b1, la, lw, 1'b1, 1'b0, 1'b0);
`else
      if (k == 15) pv(1'b0, hi_b, 1'b1, 1'b0, 1'b1, la, lw, 1'b0, 1'b1, 1'b0);
      else         pv(1'b0, hi_b, 1'b1, 1'b1, 1'b1, la, lw, 1'b1, 1'b0, 1'b0);
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    pv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd15, 16'hCF0F, 1'b0, 1'b1, 1'b0);
`endif
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd15, 16'hCF0F, 1'b0, 1'b0, 1'b0);

    // reset between low and high byte of word 1, then a fresh frame at addr 0
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd15, 16'hCF0F, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 4'd15, 16'hCF0F, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 4'd15, 16'hCF0F, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 4'd0,  16'h2211, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 4'd0,  16'h2211, 1'b1, 1'b0, 1'b0);
    pv(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h66, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    pv(1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 4'd0,  16'h5566, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 4'd0,  16'h5566, 1'b0, 1'b1, 1'b0);
`else
    pv(1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 4'd0,  16'h5566, 1'b0, 1'b1, 1'b0);
`endif
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0,  16'h5566, 1'b0, 1'b0, 1'b0);

    // valid held high through a 3-word frame; byte offered during DONE is held, then a zero-count frame
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 16'h5566, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 4'd0, 16'h5566, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 4'd0, 16'h5566, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0201, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0201, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0403, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0403, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    pv(1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0605, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0605, 1'b0, 1'b1, 1'b0);
`else
    pv(1'b0, 8'h06, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0605, 1'b0, 1'b1, 1'b0);
`endif
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0605, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0605, 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    pv(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0605, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0605, 1'b0, 1'b1, 1'b0);
`else
    pv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0605, 1'b0, 1'b1, 1'b0);
`endif
    pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0605, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      in_data  = vecs[i].data;
      in_valid = vecs[i].valid;
      @(posedge clk);
      #1;
      chk(i, "in_ready",   16'(in_ready),   16'(vecs[i].rdy));
      chk(i, "imem_we",    16'(imem_we),    16'(vecs[i].we));
      chk(i, "imem_addr",  16'(imem_addr),  16'(vecs[i].addr));
      chk(i, "imem_wdata", imem_wdata,      vecs[i].wd);
      chk(i, "cpu_hold",   16'(cpu_hold),   16'(vecs[i].hold));
      chk(i, "load_done",  16'(load_done),  16'(vecs[i].done));
      chk(i, "load_err",   16'(load_err),   16'(vecs[i].err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
